// File: rtl/mem_interface_pipelined.sv
// Single-port word memory with a valid/ready request channel, a fixed-latency
// in-order response pipeline, out-of-range detection and optional clear after reset.
module mem_interface_pipelined #(
  parameter int DATA_WIDTH     = 19,
  parameter int ADDR_WIDTH     = 19,
  parameter int DEPTH          = 2**ADDR_WIDTH,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_is_write,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  init_done
);

  localparam int unsigned RL    = READ_LATENCY;
  localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH+1)'(DEPTH - 1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;
  localparam logic [0:0] S_RESET = CLEAR_ON_RESET ? S_CLEAR : S_READY;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
  logic                  accept;
  logic                  in_range;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [RL-1:0]         pv_q, pw_q, pe_q;
  logic [DATA_WIDTH-1:0] pd_q [RL];

  // Gating with rst keeps ready/init_done low for every cycle rst is held.
  assign req_ready = (state_q == S_READY) && !rst;
  assign init_done = (state_q == S_READY) && !rst;
  assign accept    = req_valid && req_ready;
  assign in_range  = {1'b0, req_addr} < DEPTH_W;
  assign rd_data   = in_range ? mem_q[req_addr[IDX_W-1:0]] : '0;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = req_addr[IDX_W-1:0];
    mem_wdata = req_wdata;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q[IDX_W-1:0];
      mem_wdata = '0;
      if (clr_cnt_q == LAST_W) begin
        state_d = S_READY;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end else begin
      mem_we = accept && req_write && in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RESET;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Non-valid stages carry zeros, so the last stage drives the outputs directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      pw_q <= '0;
      pe_q <= '0;
      for (int unsigned i = 0; i < RL; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= accept;
      pw_q[0] <= accept && req_write;
      pe_q[0] <= accept && !in_range;
      pd_q[0] <= (accept && !req_write) ? rd_data : '0;
      for (int unsigned i = 1; i < RL; i++) begin
        pv_q[i] <= pv_q[i-1];
        pw_q[i] <= pw_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign resp_valid    = pv_q[RL-1];
  assign resp_is_write = pw_q[RL-1];
  assign resp_err      = pe_q[RL-1];
  assign resp_rdata    = pd_q[RL-1];

endmodule

// File: tb/tb_mem_interface_pipelined.sv
// Directed bench for mem_interface_pipelined: two instances (RL=2 with clear,
// RL=4 without clear) checked every cycle against a transaction-level model.
module tb_mem_interface_pipelined;

  localparam int DEPTH = 20;

  typedef struct { int due; bit w; bit e; logic [7:0] d; } exp_t;
  typedef struct { int at;  bit w; bit e; logic [7:0] d; } rsp_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       req_valid_a, req_ready_a, req_write_a;
  logic       req_valid_b, req_ready_b, req_write_b;
  logic [4:0] req_addr_a, req_addr_b;
  logic [7:0] req_wdata_a, req_wdata_b;
  logic       resp_valid_a, resp_is_write_a, resp_err_a, init_done_a;
  logic       resp_valid_b, resp_is_write_b, resp_err_b, init_done_b;
  logic [7:0] resp_rdata_a, resp_rdata_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rst_edge_a = 0;
  bit   seen_a = 0, seen_b = 0, started = 0;
  logic [7:0] mem_a [DEPTH];
  logic [7:0] mem_b [DEPTH];
  exp_t qa[$], qb[$];
  rsp_t la[$], lb[$];

  always #5 clk = ~clk;

  mem_interface_pipelined #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(DEPTH), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .resp_valid(resp_valid_a), .resp_is_write(resp_is_write_a), .resp_err(resp_err_a),
    .resp_rdata(resp_rdata_a), .init_done(init_done_a)
  );

  mem_interface_pipelined #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(DEPTH), .READ_LATENCY(4), .CLEAR_ON_RESET(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .resp_valid(resp_valid_b), .resp_is_write(resp_is_write_b), .resp_err(resp_err_b),
    .resp_rdata(resp_rdata_b), .init_done(init_done_b)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Model readiness: A becomes ready DEPTH cycles after its last reset edge, B at once.
  function automatic bit ready_a_m();
    return !rst_a && seen_a && (cyc - rst_edge_a >= DEPTH);
  endfunction

  function automatic bit ready_b_m();
    return !rst_b && seen_b;
  endfunction

  always @(posedge clk) begin
    bit   acc_a, acc_b, err;
    exp_t x;
    acc_a = req_valid_a && ready_a_m();
    acc_b = req_valid_b && ready_b_m();
    cyc++;
    if (rst_a) begin
      qa.delete();
      rst_edge_a = cyc;
      seen_a = 1;
      for (int i = 0; i < DEPTH; i++) mem_a[i] = 8'h00;
    end else if (acc_a) begin
      err = (req_addr_a >= DEPTH);
      x = '{due: cyc + 1, w: req_write_a, e: err, d: 8'h00};
      if (!req_write_a && !err) x.d = mem_a[req_addr_a];
      if (req_write_a && !err) mem_a[req_addr_a] = req_wdata_a;
      qa.push_back(x);
    end
    if (rst_b) begin
      qb.delete();
      seen_b = 1;
    end else if (acc_b) begin
      err = (req_addr_b >= DEPTH);
      x = '{due: cyc + 3, w: req_write_b, e: err, d: 8'h00};
      if (!req_write_b && !err) x.d = mem_b[req_addr_b];
      if (req_write_b && !err) mem_b[req_addr_b] = req_wdata_b;
      qb.push_back(x);
    end
  end

  task automatic chk(input string nm, input logic rdy, input logic ini, input bit rdy_exp,
                     input logic v, input logic w, input logic e, input logic [7:0] d,
                     input bit hv, input exp_t x);
    cmp({nm, "_req_ready"}, rdy, rdy_exp);
    cmp({nm, "_init_done"}, ini, rdy_exp);
    cmp({nm, "_resp_valid"}, v, hv);
    cmp({nm, "_resp_is_write"}, w, hv ? x.w : 1'b0);
    cmp({nm, "_resp_err"}, e, hv ? x.e : 1'b0);
    cmp({nm, "_resp_rdata"}, d, hv ? x.d : 8'h00);
  endtask

  // Log entries record the edge at which a consumer captures the response.
  always @(negedge clk) begin
    exp_t xa, xb;
    bit   ha, hb;
    if (started) begin
      ha = 0; hb = 0;
      xa = '{due: 0, w: 0, e: 0, d: 8'h00};
      xb = xa;
      if (qa.size() > 0 && qa[0].due == cyc) begin xa = qa.pop_front(); ha = 1; end
      if (qb.size() > 0 && qb[0].due == cyc) begin xb = qb.pop_front(); hb = 1; end
      chk("A", req_ready_a, init_done_a, ready_a_m(), resp_valid_a, resp_is_write_a,
          resp_err_a, resp_rdata_a, ha, xa);
      chk("B", req_ready_b, init_done_b, ready_b_m(), resp_valid_b, resp_is_write_b,
          resp_err_b, resp_rdata_b, hb, xb);
      if (resp_valid_a === 1'b1) la.push_back('{cyc + 1, resp_is_write_a, resp_err_a, resp_rdata_a});
      if (resp_valid_b === 1'b1) lb.push_back('{cyc + 1, resp_is_write_b, resp_err_b, resp_rdata_b});
    end
  end

  task automatic send(input bit b, input bit w, input logic [4:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    if (!b) begin
      req_valid_a = 1'b1; req_write_a = w; req_addr_a = a; req_wdata_a = d;
    end else begin
      req_valid_b = 1'b1; req_write_b = w; req_addr_b = a; req_wdata_b = d;
    end
  endtask

  task automatic idle(output int acc);
    @(posedge clk); #1;
    acc = cyc;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  task automatic wait_ready_a(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (req_ready_a === 1'b1) break;
      cmp("A_init_done_during_clear", init_done_a, 1'b0);
      n++;
    end
  endtask

  initial begin
    int n, acc;
    rst_a = 1'b1; rst_b = 1'b1;
    req_valid_a = 1'b0; req_write_a = 1'b0; req_addr_a = '0; req_wdata_a = '0;
    req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;
    for (int i = 0; i < DEPTH; i++) mem_b[i] = 8'h00;
    @(posedge clk); #1;
    started = 1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    wait_ready_a(n);
    cmp("A_first_clear_cycles", n, 20);

    // junk everywhere, then a one-cycle reset pulse with a read already waiting
    for (int i = 0; i < DEPTH; i++) send(0, 1'b1, 5'(i), 8'hC0 + 8'(i));
    idle(acc);
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    req_valid_a = 1'b1; req_write_a = 1'b0; req_addr_a = 5'd7;
    wait_ready_a(n);
    cmp("A_clear_cycles", n, 20);
    la.delete();
    idle(acc);
    repeat (4) @(negedge clk);
    cmp("rd7_count", la.size(), 1);
    if (la.size() >= 1) begin
      cmp("rd7_latency", la[0].at - acc, 2);
      cmp("rd7_rdata", la[0].d, 8'h00);
      cmp("rd7_err", la[0].e, 1'b0);
    end

    // write then read-after-write on the next cycle
    la.delete();
    send(0, 1'b1, 5'd3, 8'hA5);
    send(0, 1'b0, 5'd3, 8'h00);
    idle(acc);
    repeat (4) @(negedge clk);
    cmp("raw_count", la.size(), 2);
    if (la.size() >= 2) begin
      cmp("raw_wr_is_write", la[0].w, 1'b1);
      cmp("raw_wr_rdata", la[0].d, 8'h00);
      cmp("raw_wr_at", la[0].at, acc + 1);
      cmp("raw_rd_is_write", la[1].w, 1'b0);
      cmp("raw_rd_rdata", la[1].d, 8'hA5);
      cmp("raw_rd_at", la[1].at, acc + 2);
    end

    // back-to-back stream
    la.delete();
    for (int i = 0; i < 5; i++) send(0, 1'b1, 5'(i), 8'h10 + 8'(i));
    for (int i = 4; i >= 0; i--) send(0, 1'b0, 5'(i), 8'h00);
    idle(acc);
    repeat (4) @(negedge clk);
    cmp("stream_count", la.size(), 10);
    if (la.size() == 10) begin
      cmp("stream_back_to_back", la[9].at - la[0].at, 9);
      for (int k = 0; k < 5; k++) cmp("stream_rdata", la[5+k].d, 8'h14 - 8'(k));
    end

    // out-of-range accesses and last legal word
    la.delete();
    send(0, 1'b1, 5'd25, 8'hFF);
    send(0, 1'b0, 5'd25, 8'h00);
    send(0, 1'b0, 5'd19, 8'h00);
    idle(acc);
    repeat (4) @(negedge clk);
    cmp("oor_count", la.size(), 3);
    if (la.size() == 3) begin
      cmp("oor_wr_err", la[0].e, 1'b1);
      cmp("oor_wr_is_write", la[0].w, 1'b1);
      cmp("oor_rd_err", la[1].e, 1'b1);
      cmp("oor_rd_rdata", la[1].d, 8'h00);
      cmp("rd19_err", la[2].e, 1'b0);
      cmp("rd19_rdata", la[2].d, 8'h00);
    end
    la.delete();
    for (int i = 0; i < DEPTH; i++) send(0, 1'b0, 5'(i), 8'h00);
    idle(acc);
    repeat (4) @(negedge clk);
    cmp("sweep_count", la.size(), DEPTH);
    if (la.size() == DEPTH)
      for (int i = 0; i < DEPTH; i++) cmp("sweep_rdata", la[i].d, (i < 5) ? 8'h10 + 8'(i) : 8'h00);

    // reset one cycle after a read is accepted
    la.delete();
    send(0, 1'b0, 5'd2, 8'h00);
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    wait_ready_a(n);
    cmp("midrst_clear_cycles", n, 20);
    cmp("midrst_no_resp", la.size(), 0);
    send(0, 1'b0, 5'd2, 8'h00);
    idle(acc);
    repeat (4) @(negedge clk);
    cmp("midrst_rd2_rdata", (la.size() == 1) ? la[0].d : 8'hEE, 8'h00);

    // instance B: no clear, latency 4
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    cmp("B_ready_first_cycle", req_ready_b, 1'b1);
    lb.delete();
    send(1, 1'b1, 5'd1, 8'h3C);
    send(1, 1'b0, 5'd1, 8'h00);
    idle(acc);
    repeat (6) @(negedge clk);
    cmp("B_count", lb.size(), 2);
    if (lb.size() == 2) begin
      cmp("B_wr_latency", lb[0].at - (acc - 1), 4);
      cmp("B_rd_latency", lb[1].at - acc, 4);
      cmp("B_rd_rdata", lb[1].d, 8'h3C);
      cmp("B_rd_is_write", lb[1].w, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_interface_pipelined.md
Name: mem_interface_pipelined

Overview:
- Parametrised single-port word memory with a valid/ready request channel and a fixed-latency, in-order response channel.
- Adds several capabilities: registered read with configurable latency, write acknowledgement, out-of-range address detection, and hardware clear-on-reset.
- Sits between the datapath load/store unit and on-chip storage. Default geometry is 19-bit words and 19-bit addresses.

Parameters:
DATA_WIDTH, 19, word width in bits
ADDR_WIDTH, 19, address width in bits
DEPTH, 2**ADDR_WIDTH, number of implemented words; must satisfy DEPTH <= 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..4
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests; 0 = skip clear

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block accepts a request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
resp_valid  out  1  response present (one cycle pulse per request)
resp_is_write  out  1  response belongs to a write
resp_err  out  1  request address was >= DEPTH
resp_rdata  out  DATA_WIDTH  read data (0 for writes and errored reads)
init_done  out  1  clear sequence complete, block operational

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: req_ready=0, resp_valid=0, resp_is_write=0, resp_err=0, resp_rdata=0, init_done=0. Response pipeline flushed. Memory contents are not reset by rst itself.
- FSM states: CLEAR and READY.
- CLEAR:
  - Entered on the first cycle with rst=0 after reset, if CLEAR_ON_RESET=1.
  - Writes 0 to one word per cycle, addr 0..DEPTH-1 ascending.
  - req_ready=0 throughout.
  - After writing DEPTH-1, moves to READY on the next edge.
  - Total: DEPTH cycles.
- With CLEAR_ON_RESET=0, the FSM goes directly to READY on the first cycle after rst deasserts.
- READY:
  - init_done=1 and req_ready=1 continuously; there is no response backpressure.
  - A request is accepted on any edge where req_valid && req_ready.
- Write acceptance:
  - If addr < DEPTH, memory[addr] <= req_wdata at that edge.
  - If addr >= DEPTH, no memory update and err=1.
- Read acceptance:
  - Data is sampled from memory at the accepting edge.
  - Sampled value is 0 and err=1 if addr >= DEPTH.
- Response timing:
  - Every accepted request produces exactly one resp_valid pulse, READ_LATENCY cycles after acceptance.
  - resp_is_write, resp_err and resp_rdata are valid in that same cycle, and responses are strictly in order.
  - Throughput is one request per cycle.
- Ordering: a write accepted at edge N is visible to a read accepted at edge N+1 or later. Only one request exists per cycle, so there are no same-cycle conflicts.
- When resp_valid=0, resp_rdata, resp_is_write and resp_err are driven to 0.
- Reset mid-operation (rst=1 in any state):
  - In-flight responses are discarded; no resp_valid is emitted for them.
  - Outputs return to reset values.
  - CLEAR restarts from address 0.
  - A partial clear never sets init_done.
- Address arithmetic:
  - The clear counter is ADDR_WIDTH+1 bits wide, so it cannot wrap when DEPTH = 2**ADDR_WIDTH.
  - The error compare is unsigned.

Test Plan:
- Params DW=8, AW=5, DEPTH=20, RL=2, CLR=1. Preload junk via backdoor, pulse rst 1 cycle, then hold req_valid=1 → req_ready=0 for exactly 20 cycles, then init_done=1; read addr 7 → resp_valid at +2 with rdata=0x00, err=0.
- Write 0xA5 to addr 3, then read addr 3 on the very next cycle → two responses at +2 and +3: (is_write=1, rdata=0) then (is_write=0, rdata=0xA5).
- Back-to-back stream: writes addr0..4 = 0x10..0x14, then reads addr4..0 on consecutive cycles → 10 consecutive resp_valid cycles; read data 0x14,0x13,0x12,0x11,0x10 in order.
- Write 0xFF to addr 25 (≥DEPTH), then read addr 25 and addr 19 → write resp err=1; read of 25 gives err=1, rdata=0; read of 19 gives err=0, rdata=0x00; no other word altered.
- Issue reads at RL=2, assert rst one cycle after acceptance → no resp_valid appears; clear restarts and takes 20 cycles again; init_done stays 0 until done.
- Params RL=4, CLR=0 → req_ready=1 on the first cycle after rst deasserts; write 0x3C to addr 1, read addr 1 → read resp_valid exactly 4 cycles after acceptance, rdata=0x3C.
